ace_ccu_inflight_sched: RTL and testbench

Request scheduler in front of the ACE cache-coherency unit (CCU) datapath. It accepts coherent transactions from `NoReqs` slave-port requesters and records each admitted transaction's address range in a table of `NoSlots` in-flight slots. Each cycle it grants one request whose range does not overlap any in-flight range, using round-robin among eligible requesters. This serializes same-line coherent traffic into the CCU snoop/memory path.

---
 rtl/ace_pkg.sv | 22 ++
 rtl/ace_ccu_slot_table.sv | 59 +++++
 rtl/ace_ccu_inflight_sched.sv | 94 +++++++++
 tb/tb_ace_ccu_inflight_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// ace_pkg: ACE transaction types, in-flight slot record and inclusive range collision helper
package ace_pkg;
  typedef enum logic [2:0] {
    READ_NO_SNOOP  = 3'd0,
    READ_ONCE      = 3'd1,
    READ_SHARED    = 3'd2,
    READ_UNIQUE    = 3'd3,
    CLEAN_UNIQUE   = 3'd4,
    WRITE_NO_SNOOP = 3'd5,
    WRITE_BACK     = 3'd6,
    WRITE_UNIQUE   = 3'd7
  } ace_trs_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } ccu_slot_t;
  function automatic logic check_collision(input logic [63:0] a_start, input logic [63:0] a_end,
                                           input logic [63:0] b_start, input logic [63:0] b_end);
    return (a_start <= b_end) && (b_start <= a_end);
  endfunction
endpackage

// File: rtl/ace_ccu_slot_table.sv
// ace_ccu_slot_table: in-flight address slots, per-requester collision vector, free-slot encoder, occupancy
module ace_ccu_slot_table
  import ace_pkg::*;
#(
  parameter int NoReqs    = 2,
  parameter int NoSlots   = 4,
  parameter int AddrWidth = 64,
  parameter int SW        = (NoSlots > 1) ? $clog2(NoSlots) : 1,
  parameter int OW        = $clog2(NoSlots + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NoReqs-1:0][AddrWidth-1:0]    req_start_addr,
  input  logic [NoReqs-1:0][AddrWidth-1:0]    req_end_addr,
  input  logic                                alloc_valid,
  input  logic [63:0]                         alloc_start,
  input  logic [63:0]                         alloc_end,
  input  logic                                done_valid,
  input  logic [SW-1:0]                       done_slot,
  output logic [NoReqs-1:0]                   collide,
  output logic                                free_any,
  output logic [SW-1:0]                       free_slot,
  output logic [OW-1:0]                       occupancy
);
  ccu_slot_t [NoSlots-1:0] slots;
  // frees completed slots, then allocates the lowest free slot so a same-slot alloc wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots <= '0;
    end else begin
      for (int s = 0; s < NoSlots; s++) begin
        if (done_valid && done_slot == SW'(s)) slots[s].valid <= 1'b0;
        if (alloc_valid && free_slot == SW'(s)) slots[s] <= '{valid: 1'b1, start_addr: alloc_start, end_addr: alloc_end};
      end
    end
  end
  // collision per requester against every valid slot, using registered state only
  always_comb begin
    collide = '0;
    for (int r = 0; r < NoReqs; r++)
      for (int s = 0; s < NoSlots; s++)
        if (slots[s].valid && check_collision(64'(req_start_addr[r]), 64'(req_end_addr[r]),
                                              slots[s].start_addr, slots[s].end_addr))
          collide[r] = 1'b1;
  end
  // lowest-index free slot and count of occupied slots
  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    occupancy = '0;
    for (int s = NoSlots - 1; s >= 0; s--) begin
      if (!slots[s].valid) begin
        free_any  = 1'b1;
        free_slot = SW'(s);
      end
      occupancy = occupancy + OW'(slots[s].valid);
    end
  end
endmodule

// File: rtl/ace_ccu_inflight_sched.sv
// ace_ccu_inflight_sched: round-robin scheduler admitting non-overlapping coherent requests (CCU_NOSNOOP_BYPASS_EN lets no-snoop traffic skip tracking)
module ace_ccu_inflight_sched
  import ace_pkg::*;
#(
  parameter int NoReqs    = 2,
  parameter int NoSlots   = 4,
  parameter int AddrWidth = 64,
  parameter int IW        = $clog2(NoReqs),
  parameter int SW        = (NoSlots > 1) ? $clog2(NoSlots) : 1,
  parameter int OW        = $clog2(NoSlots + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NoReqs-1:0]                req_valid_i,
  output logic [NoReqs-1:0]                req_ready_o,
  input  logic [NoReqs-1:0][AddrWidth-1:0] req_start_addr_i,
  input  logic [NoReqs-1:0][AddrWidth-1:0] req_end_addr_i,
  input  logic [NoReqs-1:0][2:0]           req_trs_i,
  output logic                             gnt_valid_o,
  input  logic                             gnt_ready_i,
  output logic [IW-1:0]                    gnt_idx_o,
  output logic [SW-1:0]                    gnt_slot_o,
  output logic [2:0]                       gnt_trs_o,
  input  logic                             done_valid_i,
  input  logic [SW-1:0]                    done_slot_i,
  output logic [OW-1:0]                    occupancy_o,
  output logic                             busy_o
);
  logic [NoReqs-1:0] collide, byp, elig;
  logic              free_any, win, win_byp, out_free;
  logic [SW-1:0]     free_slot;
  logic [IW-1:0]     win_idx, rr_ptr;
  ace_ccu_slot_table #(
    .NoReqs(NoReqs), .NoSlots(NoSlots), .AddrWidth(AddrWidth), .SW(SW), .OW(OW)
  ) u_table (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_start_addr (req_start_addr_i),
    .req_end_addr   (req_end_addr_i),
    .alloc_valid    (win && !win_byp),
    .alloc_start    (64'(req_start_addr_i[win_idx])),
    .alloc_end      (64'(req_end_addr_i[win_idx])),
    .done_valid     (done_valid_i),
    .done_slot      (done_slot_i),
    .collide        (collide),
    .free_any       (free_any),
    .free_slot      (free_slot),
    .occupancy      (occupancy_o)
  );
  assign out_free = !gnt_valid_o || gnt_ready_i;
  assign win_byp  = byp[win_idx];
  assign busy_o   = (occupancy_o != '0) || gnt_valid_o;
  // no-snoop requests bypass tracking only when the bypass feature is built in
  always_comb begin
    byp = '0;
`ifdef CCU_NOSNOOP_BYPASS_EN
    for (int i = 0; i < NoReqs; i++)
      byp[i] = (req_trs_i[i] == READ_NO_SNOOP) || (req_trs_i[i] == WRITE_NO_SNOOP);
`endif
  end
  // eligibility and round-robin pick starting at rr_ptr, colliding requesters are skipped
  always_comb begin
    elig        = '0;
    win         = 1'b0;
    win_idx     = '0;
    req_ready_o = '0;
    for (int i = 0; i < NoReqs; i++)
      elig[i] = req_valid_i[i] && out_free && (byp[i] || (!collide[i] && free_any));
    for (int k = 0; k < NoReqs; k++)
      if (!win && elig[IW'((int'(rr_ptr) + k) % NoReqs)]) begin
        win     = 1'b1;
        win_idx = IW'((int'(rr_ptr) + k) % NoReqs);
      end
    if (win) req_ready_o[win_idx] = 1'b1;
  end
  // output register and round-robin pointer update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_valid_o <= 1'b0;
      gnt_idx_o   <= '0;
      gnt_slot_o  <= '0;
      gnt_trs_o   <= '0;
      rr_ptr      <= '0;
    end else if (win) begin
      gnt_valid_o <= 1'b1;
      gnt_idx_o   <= win_idx;
      gnt_slot_o  <= win_byp ? '0 : free_slot;
      gnt_trs_o   <= req_trs_i[win_idx];
      rr_ptr      <= (win_idx == IW'(NoReqs - 1)) ? '0 : win_idx + 1'b1;
    end else if (gnt_ready_i) begin
      gnt_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ace_ccu_inflight_sched.sv
// tb_ace_ccu_inflight_sched: directed self-checking bench for the in-flight scheduler
module tb_ace_ccu_inflight_sched;
  import ace_pkg::*;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][63:0] start_addr = '0;
  logic [1:0][63:0] end_addr = '0;
  logic [1:0][2:0]  trs = '0;
  logic             gnt_valid;
  logic             gnt_ready = 1'b1;
  logic             gnt_idx;
  logic [1:0]       gnt_slot;
  logic [2:0]       gnt_trs;
  logic             done_valid = 1'b0;
  logic [1:0]       done_slot = '0;
  logic [2:0]       occupancy;
  logic             busy;
  int errors = 0;
  int checks = 0;
  ace_ccu_inflight_sched dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_start_addr_i (start_addr),
    .req_end_addr_i   (end_addr),
    .req_trs_i        (trs),
    .gnt_valid_o      (gnt_valid),
    .gnt_ready_i      (gnt_ready),
    .gnt_idx_o        (gnt_idx),
    .gnt_slot_o       (gnt_slot),
    .gnt_trs_o        (gnt_trs),
    .done_valid_i     (done_valid),
    .done_slot_i      (done_slot),
    .occupancy_o      (occupancy),
    .busy_o           (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic [63:0] s, input logic [63:0] e, input logic [2:0] t);
    req_valid[i]  = v;
    start_addr[i] = s;
    end_addr[i]   = e;
    trs[i]        = t;
  endtask
  task automatic done(input logic [1:0] s);
    done_valid = 1'b1;
    done_slot  = s;
    step();
    done_valid = 1'b0;
    #1;
  endtask
  initial begin
    logic [63:0] a0, a1;
    logic [1:0]  exp_ready;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_gnt_idx", gnt_idx, 0);
    chk("rst_gnt_slot", gnt_slot, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    set_req(0, 1, 64'h1000, 64'h103F, READ_SHARED);
    #1;
    chk("first_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    #1;
    chk("first_gnt_valid", gnt_valid, 1);
    chk("first_gnt_idx", gnt_idx, 0);
    chk("first_gnt_slot", gnt_slot, 0);
    chk("first_gnt_trs", gnt_trs, READ_SHARED);
    chk("first_occ", occupancy, 1);
    chk("first_busy", busy, 1);
    set_req(1, 1, 64'h1020, 64'h105F, READ_UNIQUE);
    #1;
    chk("collide_stall", req_ready, 2'b00);
    step();
    chk("collide_no_gnt", gnt_valid, 0);
    done_valid = 1'b1;
    done_slot  = 2'd0;
    #1;
    chk("done_same_cycle_blocks", req_ready, 2'b00);
    step();
    done_valid = 1'b0;
    #1;
    chk("after_done_occ", occupancy, 0);
    chk("after_done_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    #1;
    chk("after_done_gnt_valid", gnt_valid, 1);
    chk("after_done_gnt_idx", gnt_idx, 1);
    chk("after_done_gnt_slot", gnt_slot, 0);
    chk("after_done_trs", gnt_trs, READ_UNIQUE);
    done(2'd0);
    chk("drain_occ", occupancy, 0);
    a0 = 64'h2000;
    a1 = 64'h8000;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1, a0, a0 + 64'h3F, READ_ONCE);
      set_req(1, 1, a1, a1 + 64'h3F, WRITE_BACK);
      #1;
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_ready", req_ready, exp_ready);
      step();
      chk("rr_gnt_idx", gnt_idx, k % 2);
      chk("rr_gnt_slot", gnt_slot, k);
      if (k % 2 == 0) a0 = a0 + 64'h100;
      else a1 = a1 + 64'h100;
    end
    req_valid = '0;
    #1;
    chk("full_occ", occupancy, 4);
    set_req(0, 1, 64'h2200, 64'h223F, READ_ONCE);
    #1;
    chk("full_stall", req_ready, 2'b00);
    step();
    chk("full_no_gnt", gnt_valid, 0);
    done(2'd2);
    chk("full_freed_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    #1;
    chk("full_regnt_idx", gnt_idx, 0);
    chk("full_regnt_slot", gnt_slot, 2);
    chk("full_regnt_occ", occupancy, 4);
    gnt_ready = 1'b0;
    done(2'd0);
    set_req(1, 1, 64'h9000, 64'h903F, READ_SHARED);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", req_ready, 2'b00);
      chk("hold_valid", gnt_valid, 1);
      chk("hold_idx", gnt_idx, 0);
      chk("hold_slot", gnt_slot, 2);
      step();
    end
    gnt_ready = 1'b1;
    #1;
    chk("release_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    #1;
    chk("release_gnt_idx", gnt_idx, 1);
    chk("release_gnt_slot", gnt_slot, 0);
    step();
    chk("release_cleared", gnt_valid, 0);
    chk("release_busy", busy, 1);
    done(2'd1);
    chk("incl_occ", occupancy, 3);
    set_req(0, 1, 64'h903F, 64'h9050, READ_SHARED);
    #1;
    chk("incl_edge_collides", req_ready, 2'b00);
    set_req(0, 1, 64'h9040, 64'h907F, READ_SHARED);
    #1;
    chk("incl_adjacent_ok", req_ready, 2'b01);
    set_req(0, 1, 64'h8100, 64'h8100, READ_NO_SNOOP);
    #1;
`ifdef CCU_NOSNOOP_BYPASS_EN
    chk("bypass_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    #1;
    chk("bypass_gnt_valid", gnt_valid, 1);
    chk("bypass_gnt_slot", gnt_slot, 0);
    chk("bypass_gnt_trs", gnt_trs, READ_NO_SNOOP);
    chk("bypass_occ", occupancy, 3);
`else
    chk("nosnoop_blocked", req_ready, 2'b00);
    step();
    req_valid = '0;
    #1;
    chk("nosnoop_no_gnt", gnt_valid, 0);
    chk("nosnoop_occ", occupancy, 3);
`endif
    done(2'd1);
    chk("done_free_slot_ignored", occupancy, 3);
    set_req(0, 1, 64'hA000, 64'hA03F, READ_ONCE);
    step();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_occ", occupancy, 0);
    chk("midrst_gnt_valid", gnt_valid, 0);
    chk("midrst_busy", busy, 0);
    step();
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
